// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access stage plus MEM-to-WB pipeline register.
// Loads/stores hit a word-addressed RAM after WAIT_STATES extra cycles;
// ready drops during those cycles so the core freezes the upstream stages.
// Optional macro MEM_RANGE_CHECK_EN adds a sticky addrError output and
// suppresses out-of-range stores (loads return zero) instead of wrapping.
module mem_wb_stage #(
    parameter int MEM_BASE    = 1024,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        writeBackEnIn,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    input  logic [31:0] ALUResultIn,
    input  logic [31:0] storeValIn,
    input  logic [3:0]  destinationIn,
    output logic        ready,
    output logic        writeBackEnWB,
    output logic [3:0]  destWB,
    output logic [31:0] resultWB
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic        addrError
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [3:0]     cnt;
    logic [3:0]     next_cnt;

    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  idx;
    logic           access;
    logic           addr_ok;
    logic           store_en;
    logic [31:0]    rd_data;

    // Word index relative to the RAM base; the byte offset bits are dropped
    // and the index wraps modulo DEPTH.
    assign idx    = AW'((ALUResultIn - 32'(MEM_BASE)) >> 2);
    assign access = memReadIn | memWriteIn;

`ifdef MEM_RANGE_CHECK_EN
    localparam logic [32:0] ADDR_LO = 33'(MEM_BASE);
    localparam logic [32:0] ADDR_HI = 33'(MEM_BASE) + 33'(4 * DEPTH);

    logic in_range;
    logic complete;

    assign in_range = ({1'b0, ALUResultIn} >= ADDR_LO) && ({1'b0, ALUResultIn} < ADDR_HI);
    assign addr_ok  = in_range;
    assign complete = ready & access;

    // Sticky out-of-range flag, set on the completion cycle of a bad access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrError <= 1'b0;
        end else if (complete && !in_range) begin
            addrError <= 1'b1;
        end
    end
`else
    assign addr_ok = 1'b1;
`endif

    assign store_en = ready & memWriteIn & addr_ok;
    assign rd_data  = addr_ok ? mem[idx] : '0;

    // Wait-state FSM state and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic; ready is low only while wait states remain.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        ready      = 1'b1;
        case (state)
            S_IDLE: begin
                if (access && (WAIT_STATES > 0)) begin
                    next_state = S_WAIT;
                    next_cnt   = WS_LOAD;
                    ready      = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt != 4'd0) begin
                    next_cnt = cnt - 4'd1;
                    ready    = 1'b0;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Data RAM write port; not reset, written once at the end of the completion cycle.
    always_ff @(posedge clk) begin
        if (store_en) begin
            mem[idx] <= storeValIn;
        end
    end

    // MEM-to-WB register: capture when ready, otherwise insert a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writeBackEnWB <= 1'b0;
            destWB        <= '0;
            resultWB      <= '0;
        end else if (ready) begin
            writeBackEnWB <= writeBackEnIn & ~memWriteIn;
            destWB        <= destinationIn;
            resultWB      <= memReadIn ? rd_data : ALUResultIn;
        end else begin
            writeBackEnWB <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed table-driven bench for mem_wb_stage.
// One instance uses WAIT_STATES=2, a second uses WAIT_STATES=0.
// With MEM_RANGE_CHECK_EN defined the addrError behaviour is also checked.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;

    // Stimulus/outputs for the WAIT_STATES=2 instance.
    logic        wb_in, rd_in, wr_in;
    logic [31:0] alu_in, sv_in;
    logic [3:0]  dest_in;
    logic        ready2, wb2;
    logic [3:0]  dest2;
    logic [31:0] res2;

    // Stimulus/outputs for the WAIT_STATES=0 instance.
    logic        z_wb_in, z_rd_in, z_wr_in;
    logic [31:0] z_alu_in, z_sv_in;
    logic [3:0]  z_dest_in;
    logic        ready0, wb0;
    logic [3:0]  dest0;
    logic [31:0] res0;

`ifdef MEM_RANGE_CHECK_EN
    logic        aerr2, aerr0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.MEM_BASE(1024), .DEPTH(64), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst),
        .writeBackEnIn(wb_in), .memReadIn(rd_in), .memWriteIn(wr_in),
        .ALUResultIn(alu_in), .storeValIn(sv_in), .destinationIn(dest_in),
        .ready(ready2), .writeBackEnWB(wb2), .destWB(dest2), .resultWB(res2)
`ifdef MEM_RANGE_CHECK_EN
        , .addrError(aerr2)
`endif
    );

    mem_wb_stage #(.MEM_BASE(1024), .DEPTH(64), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst),
        .writeBackEnIn(z_wb_in), .memReadIn(z_rd_in), .memWriteIn(z_wr_in),
        .ALUResultIn(z_alu_in), .storeValIn(z_sv_in), .destinationIn(z_dest_in),
        .ready(ready0), .writeBackEnWB(wb0), .destWB(dest0), .resultWB(res0)
`ifdef MEM_RANGE_CHECK_EN
        , .addrError(aerr0)
`endif
    );

    typedef struct {
        logic        wb, rd, wr;
        logic [31:0] alu, sv;
        logic [3:0]  dest;
        logic        exp_ready, exp_wb;
        logic [3:0]  exp_dest;
        logic [31:0] exp_res;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive2(input logic wb, input logic rd, input logic wr,
                          input logic [31:0] alu, input logic [31:0] sv, input logic [3:0] dest);
        wb_in = wb; rd_in = rd; wr_in = wr; alu_in = alu; sv_in = sv; dest_in = dest;
    endtask

    task automatic drive0(input logic wb, input logic rd, input logic wr,
                          input logic [31:0] alu, input logic [31:0] sv, input logic [3:0] dest);
        z_wb_in = wb; z_rd_in = rd; z_wr_in = wr; z_alu_in = alu; z_sv_in = sv; z_dest_in = dest;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // STR 1028 <- DEADBEEF (2 wait cycles, then completion)
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd0, 1'b1, 1'b0, 4'd0, 32'd1028};
        // LDR r5 <- [1028]
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd5, 1'b0, 1'b0, 4'd0, 32'd1028};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd5, 1'b0, 1'b0, 4'd0, 32'd1028};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd5, 1'b1, 1'b1, 4'd5, 32'hDEADBEEF};
        // nop, ADD r3 = 7, nop
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'd7, 32'd0, 4'd3, 1'b1, 1'b1, 4'd3, 32'd7};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0};
        // illegal read+write: store wins, old word is what the load path sees
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'd1028, 32'h1234, 4'd7, 1'b0, 1'b0, 4'd0, 32'd0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 32'd1028, 32'h1234, 4'd7, 1'b0, 1'b0, 4'd0, 32'd0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 32'd1028, 32'h1234, 4'd7, 1'b1, 1'b0, 4'd7, 32'hDEADBEEF};
        // LDR r9 <- [1028] sees the value from the illegal access
        tbl[12] = '{1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd9, 1'b0, 1'b0, 4'd7, 32'hDEADBEEF};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd9, 1'b0, 1'b0, 4'd7, 32'hDEADBEEF};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd9, 1'b1, 1'b1, 4'd9, 32'h1234};
        // STR 1032 <- A5A5 (preset for the reset-abort sequence)
        tbl[15] = '{1'b0, 1'b0, 1'b1, 32'd1032, 32'hA5A5, 4'd0, 1'b0, 1'b0, 4'd9, 32'h1234};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 32'd1032, 32'hA5A5, 4'd0, 1'b0, 1'b0, 4'd9, 32'h1234};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 32'd1032, 32'hA5A5, 4'd0, 1'b1, 1'b0, 4'd0, 32'd1032};

        rst = 1'b1;
        drive2(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, ready2}, 32'd1);
        check("reset_wb",    {31'd0, wb2},    32'd0);
        check("reset_dest",  {28'd0, dest2},  32'd0);
        check("reset_res",   res2,            32'd0);
        check("reset_ready0", {31'd0, ready0}, 32'd1);
        rst = 1'b0;
        #1;

        // Table-driven sequence on the WAIT_STATES=2 instance
        for (int i = 0; i < 18; i++) begin
            drive2(tbl[i].wb, tbl[i].rd, tbl[i].wr, tbl[i].alu, tbl[i].sv, tbl[i].dest);
            #1;
            check($sformatf("row%0d_ready", i), {31'd0, ready2}, {31'd0, tbl[i].exp_ready});
            tick();
            check($sformatf("row%0d_wb", i),   {31'd0, wb2},   {31'd0, tbl[i].exp_wb});
            check($sformatf("row%0d_dest", i), {28'd0, dest2}, {28'd0, tbl[i].exp_dest});
            check($sformatf("row%0d_res", i),  res2,           tbl[i].exp_res);
        end

`ifdef MEM_RANGE_CHECK_EN
        // Out-of-range load at 1020 returns 0 and sets the sticky error
        check("aerr_clear", {31'd0, aerr2}, 32'd0);
        drive2(1'b1, 1'b1, 1'b0, 32'd1020, 32'd0, 4'd6);
        #1;
        tick(); tick(); tick();
        check("oor_wb",   {31'd0, wb2},   32'd1);
        check("oor_dest", {28'd0, dest2}, 32'd6);
        check("oor_res",  res2,           32'd0);
        check("oor_aerr", {31'd0, aerr2}, 32'd1);
        drive2(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd1);
        #1;
        tick(); tick(); tick();
        check("inrange_res",  res2,           32'h1234);
        check("aerr_sticky",  {31'd0, aerr2}, 32'd1);
`endif

        // Reset during WAIT of STR 1032 <- 0x55: store must be aborted
        drive2(1'b0, 1'b0, 1'b1, 32'd1032, 32'h55, 4'd0);
        #1;
        check("abort_ready_a", {31'd0, ready2}, 32'd0);
        tick();
        check("abort_ready_b", {31'd0, ready2}, 32'd0);
        #1;
        rst = 1'b1;
        drive2(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #1;
        check("abort_ready", {31'd0, ready2}, 32'd1);
        check("abort_wb",    {31'd0, wb2},    32'd0);
        check("abort_dest",  {28'd0, dest2},  32'd0);
        check("abort_res",   res2,            32'd0);
`ifdef MEM_RANGE_CHECK_EN
        check("aerr_rst", {31'd0, aerr2}, 32'd0);
`endif
        tick();
        rst = 1'b0;
        drive2(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd4);
        #1;
        check("ld2_ready_a", {31'd0, ready2}, 32'd0);
        tick();
        check("ld2_ready_b", {31'd0, ready2}, 32'd0);
        tick();
        check("ld2_ready_c", {31'd0, ready2}, 32'd1);
        tick();
        check("ld2_wb",   {31'd0, wb2},   32'd1);
        check("ld2_dest", {28'd0, dest2}, 32'd4);
        check("ld2_res",  res2,           32'hA5A5);
        drive2(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        check("ld2_single", {31'd0, wb2}, 32'd0);

        // WAIT_STATES=0: back-to-back STR then LDR at 1024
        drive0(1'b0, 1'b0, 1'b1, 32'd1024, 32'h11223344, 4'd0);
        #1;
        check("z_st_ready", {31'd0, ready0}, 32'd1);
        tick();
        check("z_st_wb",  {31'd0, wb0}, 32'd0);
        check("z_st_res", res0,         32'd1024);
        drive0(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd2);
        #1;
        check("z_ld_ready", {31'd0, ready0}, 32'd1);
        tick();
        check("z_ld_wb",   {31'd0, wb0},   32'd1);
        check("z_ld_dest", {28'd0, dest0}, 32'd2);
        check("z_ld_res",  res0,           32'h11223344);
        drive0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        check("z_nop_wb", {31'd0, wb0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
